// File: rtl/bus_reader_pkg.sv
// Shared types and constants for the bus read master: source codes, FSM states,
// and small helpers used by the top module.
package bus_reader_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int SRC_W        = 4;

    localparam logic [SRC_W-1:0] SRC_G   = 4'd8;
    localparam logic [SRC_W-1:0] SRC_DIN = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Codes 0..7 name a general register; anything with bit 3 set is G, DIN or invalid.
    function automatic logic src_is_reg(input logic [SRC_W-1:0] code);
        return (code[3] == 1'b0);
    endfunction

    // Burst walk: registers advance modulo 8, G/DIN stay put and get re-sampled.
    function automatic logic [SRC_W-1:0] src_advance(input logic [SRC_W-1:0] code);
        logic [SRC_W-1:0] nxt;
        if (src_is_reg(code)) begin
            nxt = {1'b0, code[2:0] + 3'd1};
        end else begin
            nxt = code;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bus_source_mux.sv
// Combinational selection of the bus source (R0..R7, G, DIN) by a 4-bit code,
// flagging codes that name no source.
module bus_source_mux
    import bus_reader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0]          g_in,
    input  logic [DATA_W-1:0]          din,
    input  logic [SRC_W-1:0]           sel,
    output logic [DATA_W-1:0]          data,
    output logic                       src_valid
);

    logic [DATA_W-1:0] regs_s [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
        assign regs_s[i] = reg_in[i*DATA_W +: DATA_W];
    end

    // Source select; invalid codes yield zero data and src_valid low.
    always_comb begin
        data      = {DATA_W{1'b0}};
        src_valid = 1'b0;
        case (sel)
            SRC_G: begin
                data      = g_in;
                src_valid = 1'b1;
            end
            SRC_DIN: begin
                data      = din;
                src_valid = 1'b1;
            end
            default: begin
                if (src_is_reg(sel)) begin
                    data      = regs_s[sel[2:0]];
                    src_valid = 1'b1;
                end else begin
                    data      = {DATA_W{1'b0}};
                    src_valid = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/bus_reader.sv
// Read-side bus master: accepts single reads and short bursts from the control
// FSM and drives buswire from a register so negedge-clocked destinations capture it.
module bus_reader
    import bus_reader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0]          g_in,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_req,
    input  logic [SRC_W-1:0]           rd_src,
    input  logic [2:0]                 rd_len,
    input  logic                       rd_abort,
    output logic                       rd_ready,
    output logic [DATA_W-1:0]          buswire,
    output logic                       bus_valid,
    output logic                       rd_err
);

    state_e            state_r;
    logic [2:0]        remaining_r;
    logic [SRC_W-1:0]  cur_src_r;
    logic              ready_r;
    logic [DATA_W-1:0] bus_r;
    logic              valid_r;
    logic              err_r;

    logic [SRC_W-1:0]  next_src_s;
    logic [SRC_W-1:0]  sel_s;
    logic [DATA_W-1:0] mux_data_s;
    logic              src_valid_s;

    // In IDLE the mux looks at the incoming request; in BURST at the next source of the walk.
    always_comb begin
        next_src_s = src_advance(cur_src_r);
        if (state_r == ST_BURST) begin
            sel_s = next_src_s;
        end else begin
            sel_s = rd_src;
        end
    end

    bus_source_mux #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_src_mux (
        .reg_in    (reg_in),
        .g_in      (g_in),
        .din       (din),
        .sel       (sel_s),
        .data      (mux_data_s),
        .src_valid (src_valid_s)
    );

    // Control FSM with registered bus, handshake and error outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            remaining_r <= 3'd0;
            cur_src_r   <= 4'd0;
            ready_r     <= 1'b0;
            bus_r       <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            bus_r   <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (rd_req && ready_r) begin
                        if (!src_valid_s) begin
                            err_r <= 1'b1;
                        end else begin
                            bus_r   <= mux_data_s;
                            valid_r <= 1'b1;
                            if (rd_len != 3'd0) begin
                                remaining_r <= rd_len;
                                cur_src_r   <= rd_src;
                                state_r     <= ST_BURST;
                                ready_r     <= 1'b0;
                            end
                        end
                    end
                end
                ST_BURST: begin
                    if (rd_abort) begin
                        remaining_r <= 3'd0;
                        state_r     <= ST_IDLE;
                        ready_r     <= 1'b1;
                    end else begin
                        cur_src_r   <= next_src_s;
                        bus_r       <= mux_data_s;
                        valid_r     <= 1'b1;
                        remaining_r <= remaining_r - 3'd1;
                        if (remaining_r == 3'd1) begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    remaining_r <= 3'd0;
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ready  = ready_r;
    assign buswire   = bus_r;
    assign bus_valid = valid_r;
    assign rd_err    = err_r;

endmodule

// File: tb/tb_bus_reader.sv
// Directed self-checking bench for bus_reader: single reads, register/DIN bursts,
// invalid source, abort and asynchronous reset mid-burst.
module tb_bus_reader;

    logic         clock;
    logic         resetn;
    logic [127:0] reg_in;
    logic [15:0]  g_in;
    logic [15:0]  din;
    logic         rd_req;
    logic [3:0]   rd_src;
    logic [2:0]   rd_len;
    logic         rd_abort;
    logic         rd_ready;
    logic [15:0]  buswire;
    logic         bus_valid;
    logic         rd_err;

    int n_checks = 0;
    int n_errors = 0;

    bus_reader dut (
        .clock     (clock),
        .resetn    (resetn),
        .reg_in    (reg_in),
        .g_in      (g_in),
        .din       (din),
        .rd_req    (rd_req),
        .rd_src    (rd_src),
        .rd_len    (rd_len),
        .rd_abort  (rd_abort),
        .rd_ready  (rd_ready),
        .buswire   (buswire),
        .bus_valid (bus_valid),
        .rd_err    (rd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus state in one call: value, valid, ready.
    task automatic check_bus(input string tag, input logic [15:0] b, input logic v, input logic r);
        check_val({tag, ".bus"}, {16'd0, buswire}, {16'd0, b});
        check_val({tag, ".valid"}, {31'd0, bus_valid}, {31'd0, v});
        check_val({tag, ".ready"}, {31'd0, rd_ready}, {31'd0, r});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [3:0] src, input logic [2:0] len);
        rd_req = 1'b1;
        rd_src = src;
        rd_len = len;
    endtask

    initial begin
        resetn   = 1'b0;
        rd_req   = 1'b0;
        rd_src   = 4'd0;
        rd_len   = 3'd0;
        rd_abort = 1'b0;
        g_in     = 16'hBEEF;
        din      = 16'h0000;
        for (int i = 0; i < 8; i++) reg_in[i*16 +: 16] = 16'(16'h0100 + i);
        reg_in[3*16 +: 16] = 16'hA5A5;

        // Reset state
        #2;
        check_bus("rst", 16'h0000, 1'b0, 1'b0);
        check_val("rst.err", {31'd0, rd_err}, 32'd0);

        // Release between edges with a request pending: ready rises first, accept one edge later
        @(negedge clock);
        request(4'd3, 3'd0);
        resetn = 1'b1;
        tick();
        check_bus("rdy_rise", 16'h0000, 1'b0, 1'b1);
        tick();
        check_bus("single_r3", 16'hA5A5, 1'b1, 1'b1);
        rd_req = 1'b0;
        tick();
        check_bus("single_after", 16'h0000, 1'b0, 1'b1);

        // Back-to-back singles: G then R0
        request(4'd8, 3'd0);
        tick();
        check_bus("single_g", 16'hBEEF, 1'b1, 1'b1);
        request(4'd0, 3'd0);
        tick();
        check_bus("single_r0", 16'h0100, 1'b1, 1'b1);
        rd_req = 1'b0;
        reg_in[3*16 +: 16] = 16'h0103;
        tick();
        check_bus("idle0", 16'h0000, 1'b0, 1'b1);

        // Register burst with wrap 7->0; request changes during burst must be ignored
        request(4'd6, 3'd3);
        tick();
        check_bus("burst_b0", 16'h0106, 1'b1, 1'b0);
        request(4'd9, 3'd7);
        tick();
        check_bus("burst_b1", 16'h0107, 1'b1, 1'b0);
        tick();
        check_bus("burst_b2", 16'h0100, 1'b1, 1'b0);
        tick();
        check_bus("burst_b3", 16'h0101, 1'b1, 1'b1);
        rd_req = 1'b0;
        tick();
        check_bus("burst_end", 16'h0000, 1'b0, 1'b1);

        // DIN burst re-samples the live value each beat
        din = 16'h0011;
        request(4'd9, 3'd2);
        tick();
        check_bus("din_b0", 16'h0011, 1'b1, 1'b0);
        rd_req = 1'b0;
        din = 16'h0022;
        tick();
        check_bus("din_b1", 16'h0022, 1'b1, 1'b0);
        din = 16'h0033;
        tick();
        check_bus("din_b2", 16'h0033, 1'b1, 1'b1);
        tick();
        check_bus("din_end", 16'h0000, 1'b0, 1'b1);

        // Invalid source
        request(4'd12, 3'd2);
        tick();
        check_val("inv.err", {31'd0, rd_err}, 32'd1);
        check_bus("inv", 16'h0000, 1'b0, 1'b1);
        rd_req = 1'b0;
        tick();
        check_val("inv.err_end", {31'd0, rd_err}, 32'd0);
        check_bus("inv_after", 16'h0000, 1'b0, 1'b1);

        // Abort at second BURST edge, then accept immediately (abort in IDLE ignored)
        request(4'd1, 3'd5);
        tick();
        check_bus("abt_b0", 16'h0101, 1'b1, 1'b0);
        rd_req = 1'b0;
        tick();
        check_bus("abt_b1", 16'h0102, 1'b1, 1'b0);
        rd_abort = 1'b1;
        tick();
        check_bus("abt_stop", 16'h0000, 1'b0, 1'b1);
        request(4'd4, 3'd0);
        tick();
        check_bus("abt_next", 16'h0104, 1'b1, 1'b1);
        rd_req   = 1'b0;
        rd_abort = 1'b0;
        tick();
        check_bus("abt_idle", 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset mid-burst
        request(4'd0, 3'd7);
        tick();
        check_bus("rb_b0", 16'h0100, 1'b1, 1'b0);
        rd_req = 1'b0;
        tick();
        check_bus("rb_b1", 16'h0101, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_bus("rb_async", 16'h0000, 1'b0, 1'b0);
        tick();
        check_bus("rb_held", 16'h0000, 1'b0, 1'b0);
        resetn = 1'b1;
        tick();
        check_bus("rb_release", 16'h0000, 1'b0, 1'b1);
        tick();
        check_bus("rb_quiet", 16'h0000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
